// File: rtl/memory_interface_multibeat.sv
// rtl/memory_interface_multibeat.sv - byte-addressed big-endian data memory, masked multi-beat access
// Optional feature macro: MEMORY_ACCESS_COUNTER_EN (completed read/write counters).
module memory_interface_multibeat #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int DEPTH_BYTES     = 4194304,
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [DATA_WIDTH/8-1:0] req_frame_mask,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    memory_done,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int CW    = $clog2(LANES + 1);
  localparam int MW    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  // REJECT holds an invalid request for one cycle so its done timing matches a single-beat access.
  typedef enum logic [1:0] {IDLE, ACCESS, REJECT, FINISH} state_t;
  state_t state, state_next;

  logic [7:0] mem [DEPTH_BYTES];

  logic                  ready_q, wr_q, err_q;
  logic [MW-1:0]         base_q;
  logic [CW-1:0]         sel_q, count_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_next;

  logic                  accept, req_ok, last_beat, seen_c, prev_c;
  logic [CW-1:0]         sel_c, first_c, runs_c;
  logic [63:0]           end_addr;

  function automatic logic [MW-1:0] byte_addr(input logic [MW-1:0] base,
                                              input logic [CW-1:0] done, input int j);
    return base + MW'(done) + MW'(j);
  endfunction

  // Frame byte k sits at bit 8*(sel-k-1): the lowest address is the most significant byte.
  function automatic int beat_shift(input logic [CW-1:0] sel, input logic [CW-1:0] done,
                                    input int j);
    return 8 * (int'(sel) - int'(done) - j - 1);
  endfunction

  always_comb begin
    sel_c   = '0;
    first_c = '0;
    runs_c  = '0;
    seen_c  = 1'b0;
    prev_c  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (req_frame_mask[LANES-1-i]) begin
        sel_c = sel_c + CW'(1);
        if (!seen_c) first_c = CW'(i);
        seen_c = 1'b1;
        if (!prev_c) runs_c = runs_c + CW'(1);
      end
      prev_c = req_frame_mask[LANES-1-i];
    end
  end

  assign end_addr  = 64'(req_address) + 64'(first_c) + 64'(sel_c) - 64'd1;
  assign req_ok    = (sel_c != '0) && (runs_c == CW'(1)) && (end_addr < 64'(DEPTH_BYTES));
  assign accept    = req_valid && ready_q;
  assign last_beat = (int'(count_q) + BYTES_PER_CYCLE) >= int'(sel_q);

  always_ff @(posedge CLK) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_ok ? ACCESS : REJECT;
      ACCESS:  if (last_beat) state_next = FINISH;
      REJECT:  state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata_next = rdata_q;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      if (int'(count_q) + j < int'(sel_q))
        rdata_next = rdata_next | (DATA_WIDTH'(mem[byte_addr(base_q, count_q, j)])
                                   << beat_shift(sel_q, count_q, j));
    end
  end

  // Gated by reset_n so a beat landing on a reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (reset_n && state == ACCESS && wr_q) begin
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
        if (int'(count_q) + j < int'(sel_q))
          mem[byte_addr(base_q, count_q, j)] <= 8'(wdata_q >> beat_shift(sel_q, count_q, j));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      sel_q   <= '0;
      count_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ready_q <= (state_next == IDLE);
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= !req_ok;
        base_q  <= MW'(req_address + ADDR_WIDTH'(first_c));
        sel_q   <= sel_c;
        count_q <= '0;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end else if (state == ACCESS) begin
        count_q <= count_q + CW'(BYTES_PER_CYCLE);
        if (!wr_q) rdata_q <= rdata_next;
      end
    end
  end

  assign req_ready   = ready_q;
  assign memory_done = (state == FINISH);
  assign resp_rdata  = rdata_q;
  assign resp_error  = err_q;

`ifdef MEMORY_ACCESS_COUNTER_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state == FINISH && !err_q) begin
      if (wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;
`else
  assign read_count  = '0;
  assign write_count = '0;
`endif

endmodule

// File: tb/tb_memory_interface_multibeat.sv
// tb/tb_memory_interface_multibeat.sv - scoreboard bench with a byte-array reference model
`timescale 1ns/1ps
module tb_memory_interface_multibeat;
  localparam int DW = 32, AW = 16, DEPTH = 1024, BPC = 2, LANES = DW / 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid, req_ready, req_write;
  logic [AW-1:0]    req_address;
  logic [LANES-1:0] req_frame_mask;
  logic [DW-1:0]    req_wdata;
  logic             memory_done, resp_error;
  logic [DW-1:0]    resp_rdata;
  logic [31:0]      read_count, write_count;

  always #5 clk = ~clk;

  memory_interface_multibeat #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_BYTES(DEPTH), .BYTES_PER_CYCLE(BPC)
  ) dut (
    .CLK(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_frame_mask(req_frame_mask),
    .req_wdata(req_wdata), .memory_done(memory_done), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .read_count(read_count), .write_count(write_count)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
    longint        t;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  longint     mon_lat;
  logic [7:0] ref_mem [DEPTH];
  int         ref_reads = 0, ref_writes = 0;
  int         n_checks = 0, n_pass = 0, done_seen = 0;
  longint     prev_acc = 0;
  int         prev_lat = 0;
  bit         prev_keep = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endfunction

  // Reference: a request is a contiguous run of sel bytes starting at address+first.
  task automatic issue(input bit wr, input int addr, input logic [LANES-1:0] mask,
                       input logic [DW-1:0] wd, input bit keep);
    exp_t e;
    int   w = 0;
    int   sel, first;
    bit   ok;
    req_valid = 1'b1; req_write = wr; req_address = AW'(addr);
    req_frame_mask = mask; req_wdata = wd;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    chk("accept_timeout", 64'(w < 100), 64'd1);
    @(posedge clk);
    e.t = $time;
    sel = $countones(mask);
    first = 0;
    while (first < LANES && !mask[LANES-1-first]) first++;
    ok = (sel > 0) && (int'(mask) == (((1 << sel) - 1) << (LANES - first - sel)))
         && (addr + first + sel - 1 < DEPTH);
    e.err = !ok;
    e.rdata = '0;
    e.lat = ok ? (sel + BPC - 1) / BPC : 1;
    if (ok) begin
      for (int k = 0; k < sel; k++) begin
        if (wr) ref_mem[addr+first+k] = wd[8*(sel-1-k) +: 8];
        else    e.rdata = (e.rdata << 8) | DW'(ref_mem[addr+first+k]);
      end
      if (wr) ref_writes++; else ref_reads++;
    end
    if (prev_keep) chk("b2b_spacing", 64'(e.t - prev_acc), 64'((prev_lat + 2) * 10));
    prev_keep = keep; prev_acc = e.t; prev_lat = e.lat;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) begin
      req_valid = 1'b0;
      req_address = AW'($urandom); req_wdata = $urandom;
      req_frame_mask = LANES'($urandom); req_write = 1'($urandom);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("drain_responses", 64'(exp_q.size()), 64'd0);
    prev_keep = 0;
  endtask

  always @(negedge clk) begin
    if (memory_done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        mon_lat = ($time - mon_e.t - 5) / 10;
        chk("resp_error", 64'(resp_error), 64'(mon_e.err));
        chk("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
        chk("done_latency", 64'(mon_lat), 64'(mon_e.lat));
      end
    end
  end

  task automatic reset_mid_write();
    int d0, w = 0;
    logic [DW-1:0] wd = 32'h11223344;
    req_valid = 1'b1; req_write = 1'b1; req_address = 16'h200;
    req_frame_mask = 4'hF; req_wdata = wd;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    chk("accept_timeout", 64'(w < 100), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    d0 = done_seen;
    reset_n = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("no_done_on_abort", 64'(done_seen - d0), 64'd0);
    chk("read_count_reset", 64'(read_count), 64'd0);
    chk("write_count_reset", 64'(write_count), 64'd0);
    for (int k = 0; k < BPC; k++) ref_mem[16'h200 + k] = wd[8*(3-k) +: 8];
    ref_reads = 0; ref_writes = 0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_address = '0; req_frame_mask = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_done", 64'(memory_done), 64'd0);
    chk("reset_rdata", 64'(resp_rdata), 64'd0);
    chk("reset_error", 64'(resp_error), 64'd0);
    chk("reset_read_count", 64'(read_count), 64'd0);
    chk("reset_write_count", 64'(write_count), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    for (int a = 0; a < DEPTH; a += 4) issue(1'b1, a, 4'hF, $urandom, 1'b1);
    req_valid = 1'b0;
    drain();

    issue(1'b1, 'h100, 4'hF, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 'h100, 4'h1, '0, 1'b0);
    issue(1'b0, 'h100, 4'hC, '0, 1'b0);
    issue(1'b0, 'h100, 4'h6, '0, 1'b0);
    issue(1'b0, 'h100, 4'hF, '0, 1'b1);
    issue(1'b0, 'h100, 4'hF, '0, 1'b0);
    issue(1'b0, 'h101, 4'hE, '0, 1'b0);
    issue(1'b0, 'h100, 4'hA, '0, 1'b0);
    issue(1'b1, 'h100, 4'h0, 32'h01020304, 1'b0);
    issue(1'b1, DEPTH - 2, 4'hF, 32'hCAFEF00D, 1'b0);
    issue(1'b0, DEPTH - 2, 4'hC, '0, 1'b0);
    issue(1'b1, DEPTH - 4, 4'h1, 32'h000000A5, 1'b0);
    issue(1'b0, DEPTH - 4, 4'hF, '0, 1'b0);
    issue(1'b0, 'hFFFF, 4'h8, '0, 1'b0);
    drain();

    for (int i = 0; i < 200; i++) begin
      int a;
      bit k;
      a = ($urandom_range(0, 7) == 0) ? DEPTH - int'($urandom_range(0, 6))
                                      : int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 15) == 0) a = int'($urandom_range(0, 65535));
      k = ($urandom_range(0, 2) == 0);
      issue(1'($urandom_range(0, 1)), a, LANES'($urandom), $urandom, k);
      if (!k) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 1'b0;
    drain();

    reset_mid_write();
    issue(1'b0, 'h200, 4'hF, '0, 1'b0);
    issue(1'b1, 'h300, 4'hF, $urandom, 1'b0);
    issue(1'b1, 'h304, 4'h3, $urandom, 1'b0);
    issue(1'b1, 'h308, 4'h8, $urandom, 1'b0);
    issue(1'b0, 'h304, 4'hF, '0, 1'b0);
    issue(1'b0, 'h300, 4'h7, '0, 1'b0);
    issue(1'b1, 'h300, 4'h5, $urandom, 1'b0);
    drain();
    repeat (2) @(negedge clk);
`ifdef MEMORY_ACCESS_COUNTER_EN
    chk("write_count", 64'(write_count), 64'(ref_writes));
    chk("read_count", 64'(read_count), 64'(ref_reads));
`else
    chk("write_count_off", 64'(write_count), 64'd0);
    chk("read_count_off", 64'(read_count), 64'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
